// File: rtl/sdram_arbiter.sv
// SDRAM controller scheduler: init, auto-refresh, write and read ownership
// of the pad bus, plus the refresh interval timer and pending-refresh flag.
module sdram_arbiter #(
  parameter int unsigned REF_CYCLES = 780
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  output logic        ref_req,
  output logic        ref_miss,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic [4:0]  arb_state
);

  localparam logic [4:0] S_INIT  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [9:0] TC      = 10'(REF_CYCLES - 1);

  logic [4:0] r_state;
  logic [4:0] w_next;
  logic [9:0] r_timer;
  logic       r_ref_pending;
  logic       r_ref_miss;
  logic       r_last_wr;
  logic       w_tc;
  logic       w_to_aref;

  assign w_tc      = (r_state != S_INIT) && (r_timer == TC);
  assign w_to_aref = (r_state == S_ARBIT) && r_ref_pending;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (init_end) w_next = S_ARBIT;
      S_ARBIT: begin
        if (r_ref_pending)
          w_next = S_AREF;
        else if (wr_req && rd_req)
          w_next = r_last_wr ? S_READ : S_WRITE;
        else if (wr_req)
          w_next = S_WRITE;
        else if (rd_req)
          w_next = S_READ;
      end
      S_AREF:  if (flag_ref_end) w_next = S_ARBIT;
      S_WRITE: if (flag_wr_end) w_next = S_ARBIT;
      S_READ:  if (flag_rd_end) w_next = S_ARBIT;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == S_INIT || r_timer == TC) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 10'd1;
    end
  end

  // A new terminal count beats the grant-side clear on the same edge.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_ref_pending <= 1'b0;
      r_ref_miss    <= 1'b0;
    end else begin
      if (w_tc)
        r_ref_pending <= 1'b1;
      else if (w_to_aref)
        r_ref_pending <= 1'b0;
      if (w_tc && r_ref_pending)
        r_ref_miss <= 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_last_wr <= 1'b0;
    end else if (r_state == S_WRITE && flag_wr_end) begin
      r_last_wr <= 1'b1;
    end else if (r_state == S_READ && flag_rd_end) begin
      r_last_wr <= 1'b0;
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    unique case (1'b1)
      r_state[0]: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      r_state[1]: ;
      r_state[2]: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      r_state[3]: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_bank;
      end
      r_state[4]: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_bank;
      end
      default: ;
    endcase
  end

  assign ref_en    = r_state[2];
  assign wr_en     = r_state[3];
  assign rd_en     = r_state[4];
  assign ref_req   = r_ref_pending;
  assign ref_miss  = r_ref_miss;
  assign arb_state = r_state;

endmodule
